// File: rtl/serial_add_seq.sv
`default_nettype none
// serial_add_seq: bit-serial add/subtract over a single full-adder cell, LSB first.
// Rev 1.0

module add_1 (
  input  logic in_0,
  input  logic in_1,
  input  logic cin,
  output logic out,
  output logic cout
);
  assign out  = in_0 ^ in_1 ^ cin;
  assign cout = (in_0 & in_1) | (cin & (in_0 ^ in_1));
endmodule

module serial_add_seq #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             sub,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             carry_out,
  output logic             overflow
);
  localparam int CNT_W = $clog2(WIDTH);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state, state_nx;
  logic [WIDTH-1:0] a_sr, b_sr, result_sr;
  logic             carry;
  logic [CNT_W-1:0] count;
  logic             sum_bit, carry_nx, last_bit;

  add_1 u_add (
    .in_0 (a_sr[0]),
    .in_1 (b_sr[0]),
    .cin  (carry),
    .out  (sum_bit),
    .cout (carry_nx)
  );

  assign last_bit = (count == CNT_W'(WIDTH - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    busy     = 1'b0;
    done     = 1'b0;
    case (state)
      IDLE: if (start) state_nx = RUN;
      RUN: begin
        busy = 1'b1;
        if (last_bit) state_nx = DONE;
      end
      DONE: begin
        busy     = 1'b1;
        done     = 1'b1;
        state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  // Result flags load on the MSB step so they are already valid during DONE.
  // Overflow is the carry into the MSB XOR the carry out of it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_sr      <= '0;
      b_sr      <= '0;
      result_sr <= '0;
      carry     <= 1'b0;
      count     <= '0;
      result    <= '0;
      carry_out <= 1'b0;
      overflow  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            a_sr  <= a;
            b_sr  <= sub ? ~b : b;
            carry <= sub;
            count <= '0;
          end
        end
        RUN: begin
          a_sr      <= a_sr >> 1;
          b_sr      <= b_sr >> 1;
          result_sr <= {sum_bit, result_sr[WIDTH-1:1]};
          carry     <= carry_nx;
          if (last_bit) begin
            result    <= {sum_bit, result_sr[WIDTH-1:1]};
            carry_out <= carry_nx;
            overflow  <= carry ^ carry_nx;
          end else begin
            count <= count + CNT_W'(1);
          end
        end
        default: ;
      endcase
    end
  end
endmodule

`default_nettype wire

// File: tb/tb_serial_add_seq.sv
`default_nettype none
// Directed bench for serial_add_seq (WIDTH=8) with hand-computed expectations.

module tb_serial_add_seq;
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic       sub = 1'b0;
  logic [7:0] a = 8'h00;
  logic [7:0] b = 8'h00;
  logic       busy, done, carry_out, overflow;
  logic [7:0] result;

  int tests = 0;
  int fails = 0;
  int n_cyc;
  int busy_cyc;
  int done_cnt;

  serial_add_seq #(.WIDTH(8)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .sub       (sub),
    .a         (a),
    .b         (b),
    .busy      (busy),
    .done      (done),
    .result    (result),
    .carry_out (carry_out),
    .overflow  (overflow)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  // Launch one op at the next posedge, then count sampled cycles (negedge) until done.
  task automatic run_op(input logic [7:0] va, input logic [7:0] vb, input logic vs);
    @(negedge clk);
    a = va; b = vb; sub = vs; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    n_cyc = 0;
    busy_cyc = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      n_cyc++;
      if (busy) busy_cyc++;
      if (done) break;
    end
  endtask

  task automatic check_result(input string tag, input logic [7:0] r, input logic c, input logic v);
    check({tag, "_done"}, 32'(done), 32'd1);
    check({tag, "_result"}, 32'(result), 32'(r));
    check({tag, "_carry"}, 32'(carry_out), 32'(c));
    check({tag, "_ovf"}, 32'(overflow), 32'(v));
  endtask

  initial begin
    // Reset state, held with no start
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_result", 32'(result), 32'h00);
    check("rst_carry", 32'(carry_out), 32'd0);
    check("rst_ovf", 32'(overflow), 32'd0);

    // 0x5A + 0x3C = 0x96, signed overflow
    run_op(8'h5A, 8'h3C, 1'b0);
    check("add1_latency", 32'(n_cyc), 32'd9);
    check_result("add1", 8'h96, 1'b0, 1'b1);
    @(negedge clk);
    check("add1_done_pulse", 32'(done), 32'd0);
    check("add1_idle_busy", 32'(busy), 32'd0);
    check("add1_hold", 32'(result), 32'h96);

    // 0xFF + 0x01 wraps to 0x00 with carry
    run_op(8'hFF, 8'h01, 1'b0);
    @(negedge clk);
    if (busy) busy_cyc++;
    check("add2_busy_cycles", 32'(busy_cyc), 32'd9);
    check("add2_result", 32'(result), 32'h00);
    check("add2_carry", 32'(carry_out), 32'd1);
    check("add2_ovf", 32'(overflow), 32'd0);

    // 0x80 - 0x01 = 0x7F, no borrow, signed overflow
    run_op(8'h80, 8'h01, 1'b1);
    check_result("sub1", 8'h7F, 1'b1, 1'b1);
    // 0x10 - 0x20 = 0xF0, borrow
    run_op(8'h10, 8'h20, 1'b1);
    check_result("sub2", 8'hF0, 1'b0, 1'b0);

    // start held high: operands captured only at accept edges
    @(negedge clk);
    a = 8'h01; b = 8'h02; sub = 1'b0; start = 1'b1;
    n_cyc = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      n_cyc++;
      if (n_cyc == 3) begin a = 8'h10; b = 8'h20; sub = 1'b1; end
      if (n_cyc == 5) sub = 1'b0;
      if (done) break;
    end
    check_result("hold1", 8'h03, 1'b0, 1'b0);
    n_cyc = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      n_cyc++;
      if (n_cyc == 4) begin a = 8'h77; b = 8'h11; sub = 1'b1; end
      if (done) break;
    end
    start = 1'b0;
    check("hold_spacing", 32'(n_cyc), 32'd10);
    check_result("hold2", 8'h30, 1'b0, 1'b0);
    repeat (12) @(negedge clk);
    check("hold_stop_busy", 32'(busy), 32'd0);
    check("hold_stop_result", 32'(result), 32'h30);

    // Asynchronous reset at RUN bit 3 aborts with no done
    @(negedge clk);
    a = 8'hAA; b = 8'h55; sub = 1'b0; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (3) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("arst_busy", 32'(busy), 32'd0);
    check("arst_result", 32'(result), 32'h00);
    check("arst_carry", 32'(carry_out), 32'd0);
    check("arst_ovf", 32'(overflow), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    done_cnt = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (done || busy) done_cnt++;
    end
    check("arst_no_done", 32'(done_cnt), 32'd0);
    run_op(8'h01, 8'h01, 1'b0);
    check("post_rst_latency", 32'(n_cyc), 32'd9);
    check_result("post_rst", 8'h02, 1'b0, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

`default_nettype wire
